// File: rtl/draw_line_engine.sv
// Bresenham line rasteriser: walks (x0,y0)->(x1,y1) one step per cycle and
// emits one row-mask write per visited row over a valid/ready memory port.
module draw_line_engine #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COORD_W = 16,
  parameter int ADDR_W  = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WIDTH-1:0]   mem_mask
);

  localparam int EW = COORD_W + 3;
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(HEIGHT);

  typedef enum logic [2:0] {IDLE, CHECK, SETUP, STEP, FLUSH, FINISH} state_t;

  state_t                     state;
  logic [COORD_W-1:0]         xs, ys, xe, ye;
  logic [COORD_W-1:0]         cx, cy, dx, dy;
  logic                       sx_neg, sy_neg;
  logic signed [COORD_W+1:0]  e;
  logic [WIDTH-1:0]           acc;
  logic [ADDR_W-1:0]          racc_y;
  logic                       flush_issued;

  logic [COORD_W-1:0]         adx, ady, ncx, ncy;
  logic signed [EW-1:0]       e2, dx_s, dy_s;
  logic signed [COORD_W+1:0]  ne;
  logic                       step_x, step_y, at_end, wr_accept, stall;

  function automatic logic [WIDTH-1:0] one_hot(input logic [COORD_W-1:0] x);
    one_hot = WIDTH'(1) << x;
  endfunction

  always_comb begin
    adx       = (xe >= xs) ? (xe - xs) : (xs - xe);
    ady       = (ye >= ys) ? (ye - ys) : (ys - ye);
    dx_s      = {3'b000, dx};
    dy_s      = {3'b000, dy};
    e2        = {e, 1'b0};
    step_x    = (e2 > -dy_s);
    step_y    = (e2 < dx_s);
    ne        = e;
    if (step_x) ne = ne - {2'b00, dy};
    if (step_y) ne = ne + {2'b00, dx};
    ncx       = step_x ? (sx_neg ? cx - COORD_W'(1) : cx + COORD_W'(1)) : cx;
    ncy       = step_y ? (sy_neg ? cy - COORD_W'(1) : cy + COORD_W'(1)) : cy;
    at_end    = (cx == xe) && (cy == ye);
    wr_accept = mem_we && mem_ready;
    // A row change needs the output register; wait while it still holds an unaccepted write.
    stall     = step_y && mem_we && !mem_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_mask     <= '0;
      xs           <= '0;
      ys           <= '0;
      xe           <= '0;
      ye           <= '0;
      cx           <= '0;
      cy           <= '0;
      dx           <= '0;
      dy           <= '0;
      sx_neg       <= 1'b0;
      sy_neg       <= 1'b0;
      e            <= '0;
      acc          <= '0;
      racc_y       <= '0;
      flush_issued <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (wr_accept) mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xs    <= x0;
            ys    <= y0;
            xe    <= x1;
            ye    <= y1;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (xs >= X_LIM || xe >= X_LIM || ys >= Y_LIM || ye >= Y_LIM) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= SETUP;
          end
        end
        SETUP: begin
          dx           <= adx;
          dy           <= ady;
          sx_neg       <= (xe < xs);
          sy_neg       <= (ye < ys);
          e            <= {2'b00, adx} - {2'b00, ady};
          cx           <= xs;
          cy           <= ys;
          acc          <= one_hot(xs);
          racc_y       <= ys[ADDR_W-1:0];
          flush_issued <= 1'b0;
          state        <= STEP;
        end
        STEP: begin
          if (at_end) begin
            state <= FLUSH;
          end else if (!stall) begin
            cx <= ncx;
            cy <= ncy;
            e  <= ne;
            if (step_y) begin
              mem_we   <= 1'b1;
              mem_addr <= racc_y;
              mem_mask <= acc;
              acc      <= one_hot(ncx);
              racc_y   <= ncy[ADDR_W-1:0];
            end else begin
              acc <= acc | one_hot(ncx);
            end
          end
        end
        FLUSH: begin
          if (!flush_issued) begin
            if (!mem_we || mem_ready) begin
              mem_we       <= 1'b1;
              mem_addr     <= racc_y;
              mem_mask     <= acc;
              flush_issued <= 1'b1;
            end
          end else if (wr_accept) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_line_engine.sv
// Scoreboard bench for draw_line_engine: expected row writes are queued at
// stimulus time and a negedge monitor pops them as the memory port accepts.
module tb_draw_line_engine;

  localparam int WIDTH   = 640;
  localparam int HEIGHT  = 480;
  localparam int COORD_W = 16;
  localparam int ADDR_W  = 9;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               mem_ready = 1'b1;
  logic [COORD_W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic               busy, done, err, mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [WIDTH-1:0]   mem_mask;

  typedef struct {
    int               addr;
    logic [WIDTH-1:0] mask;
  } wr_t;

  wr_t              exp_q[$];
  wr_t              ent;
  int               total = 0, passed = 0, done_cnt = 0, err_cnt = 0, cyc = 0;
  bit               sb_off = 1'b0, ready_rand = 1'b0, prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [WIDTH-1:0]  prev_mask = '0;

  draw_line_engine #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_W(COORD_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .done(done), .err(err),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_mask(mem_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (ready_rand) mem_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check_i(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic check_v(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [WIDTH-1:0] bit_at(input int i);
    logic [WIDTH-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic push(input int a, input logic [WIDTH-1:0] m);
    exp_q.push_back('{a, m});
  endtask

  // Reference: textbook integer Bresenham over plain ints, pixels grouped by row.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, e, e2, x, y, row;
    logic [WIDTH-1:0] m;
    dx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    sx = (ax1 >= ax0) ? 1 : -1;
    sy = (ay1 >= ay0) ? 1 : -1;
    e = dx - dy;
    x = ax0;
    y = ay0;
    row = y;
    m = bit_at(x);
    while (x != ax1 || y != ay1) begin
      e2 = 2 * e;
      if (e2 > -dy) begin e -= dy; x += sx; end
      if (e2 < dx)  begin e += dx; y += sy; end
      if (y != row) begin
        push(row, m);
        row = y;
        m = '0;
      end
      m[x] = 1'b1;
    end
    push(row, m);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_i("hold_we", int'(mem_we), 1);
        check_i("hold_addr", int'(mem_addr), int'(prev_addr));
        check_v("hold_mask", mem_mask, prev_mask);
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_mask  = mem_mask;
      if (mem_we && mem_ready && !sb_off) begin
        if (exp_q.size() == 0) begin
          check_i("unexpected_write_addr", int'(mem_addr), -1);
        end else begin
          ent = exp_q.pop_front();
          check_i("wr_addr", int'(mem_addr), ent.addr);
          check_v("wr_mask", mem_mask, ent.mask);
        end
      end
      if (done) begin
        done_cnt++;
        if (!sb_off) check_i("done_before_last_write", exp_q.size(), 0);
      end
      if (err) err_cnt++;
    end
  end

  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input bit exp_err, input bit bp, input int inject,
                          input string tag, output int lat);
    int d0, r0, t0, bound, hold, adx, ady;
    bit fin;
    d0 = done_cnt;
    r0 = err_cnt;
    fin = 1'b0;
    hold = 0;
    lat = -1;
    adx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    bound = 8 * (adx + ady + 10) + 200;
    @(posedge clk); #1;
    if (bp) mem_ready = 1'b0;
    start = 1'b1;
    x0 = COORD_W'(ax0);
    y0 = COORD_W'(ay0);
    x1 = COORD_W'(ax1);
    y1 = COORD_W'(ay1);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    for (int i = 0; i < bound && !fin; i++) begin
      @(negedge clk);
      if (done || err) begin
        fin = 1'b1;
        lat = cyc - t0;
      end
      if (i == inject) begin
        start = 1'b1;
        x0 = 16'd100; y0 = 16'd100; x1 = 16'd100; y1 = 16'd300;
      end
      if (i == inject + 1) start = 1'b0;
      if (bp && mem_we && !mem_ready) begin
        check_i({tag, "_bp_addr"}, int'(mem_addr), 0);
        check_v({tag, "_bp_mask"}, mem_mask, bit_at(5));
        hold++;
        if (hold == 5) begin
          @(posedge clk); #1;
          mem_ready = 1'b1;
        end
      end
    end
    check_i({tag, "_finished"}, int'(fin), 1);
    if (bp) check_i({tag, "_bp_cycles"}, hold, 5);
    @(negedge clk);
    check_i({tag, "_pulse_one_cycle"}, int'(done | err), 0);
    check_i({tag, "_busy_low"}, int'(busy), 0);
    check_i({tag, "_done_count"}, done_cnt - d0, exp_err ? 0 : 1);
    check_i({tag, "_err_count"}, err_cnt - r0, exp_err ? 1 : 0);
    check_i({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, rx0, ry0, rx1, ry1;
    bit bad, found;
    logic [WIDTH-1:0] m;

    repeat (2) @(posedge clk);
    #1;
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_done", int'(done), 0);
    check_i("rst_err", int'(err), 0);
    check_i("rst_we", int'(mem_we), 0);
    check_i("rst_addr", int'(mem_addr), 0);
    check_v("rst_mask", mem_mask, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vertical line, full-rate memory
    for (int r = 60; r <= 200; r++) push(r, bit_at(260));
    run_line(260, 60, 260, 200, 1'b0, 1'b0, -1, "vert", lat);
    check_i("vert_cycles_within_bound", int'(lat <= 146 && lat >= 3), 1);

    // Horizontal lines, both directions
    m = '0;
    for (int i = 10; i <= 20; i++) m[i] = 1'b1;
    push(5, m);
    run_line(10, 5, 20, 5, 1'b0, 1'b0, -1, "horiz_fwd", lat);
    push(5, m);
    run_line(20, 5, 10, 5, 1'b0, 1'b0, -1, "horiz_rev", lat);

    // Diagonals
    for (int i = 0; i < 4; i++) push(i, bit_at(i));
    run_line(0, 0, 3, 3, 1'b0, 1'b0, -1, "diag_a", lat);
    for (int i = 0; i < 4; i++) push(i, bit_at(3 - i));
    run_line(3, 0, 0, 3, 1'b0, 1'b0, -1, "diag_b", lat);

    // Backpressure at the first write
    for (int i = 0; i < 4; i++) push(i, bit_at(5));
    run_line(5, 0, 5, 3, 1'b0, 1'b1, -1, "bp", lat);

    // Rejections and start while busy
    run_line(640, 0, 0, 0, 1'b1, 1'b0, -1, "rej_x", lat);
    run_line(0, 0, 0, 480, 1'b1, 1'b0, -1, "rej_y", lat);
    model_line(0, 0, 3, 3);
    run_line(0, 0, 3, 3, 1'b0, 1'b0, 2, "busy_start", lat);
    repeat (20) @(negedge clk);
    check_i("busy_start_no_relaunch", int'(busy), 0);

    // Random lines with random backpressure and occasional bad coordinates
    ready_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rx0 = $urandom_range(0, WIDTH - 1);
      ry0 = $urandom_range(0, HEIGHT - 1);
      if (n < 10) begin
        rx1 = $urandom_range(0, WIDTH - 1);
        ry1 = $urandom_range(0, HEIGHT - 1);
      end else begin
        rx1 = rx0 + $urandom_range(0, 30) - 15;
        ry1 = ry0 + $urandom_range(0, 30) - 15;
        if (rx1 < 0) rx1 = 0;
        if (rx1 > WIDTH - 1) rx1 = WIDTH - 1;
        if (ry1 < 0) ry1 = 0;
        if (ry1 > HEIGHT - 1) ry1 = HEIGHT - 1;
      end
      bad = ($urandom_range(0, 5) == 0);
      if (bad) begin
        case ($urandom_range(0, 3))
          0: rx0 = WIDTH + $urandom_range(0, 200);
          1: ry0 = HEIGHT + $urandom_range(0, 200);
          2: rx1 = WIDTH + $urandom_range(0, 200);
          default: ry1 = HEIGHT + $urandom_range(0, 200);
        endcase
      end else begin
        model_line(rx0, ry0, rx1, ry1);
      end
      run_line(rx0, ry0, rx1, ry1, bad, 1'b0, -1, "rand", lat);
    end
    ready_rand = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;

    // Reset in the middle of a vertical line
    sb_off = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    x0 = 16'd260; y0 = 16'd60; x1 = 16'd260; y1 = 16'd200;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_we && mem_addr == 9'd62) found = 1'b1;
    end
    check_i("mid_reset_third_write_seen", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check_i("mid_reset_busy", int'(busy), 0);
    check_i("mid_reset_done", int'(done), 0);
    check_i("mid_reset_err", int'(err), 0);
    check_i("mid_reset_we", int'(mem_we), 0);
    check_i("mid_reset_addr", int'(mem_addr), 0);
    check_v("mid_reset_mask", mem_mask, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    sb_off = 1'b0;
    repeat (20) @(negedge clk);
    check_i("mid_reset_no_done", done_cnt - d0, 0);
    check_i("mid_reset_idle_we", int'(mem_we), 0);
    push(1, bit_at(1));
    run_line(1, 1, 1, 1, 1'b0, 1'b0, -1, "single_pixel", lat);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/draw_line_engine.md
Name: draw_line_engine

Overview:
- Parametrised successor of the single-column line drawer: rasterises an arbitrary straight line from (x0,y0) to (x1,y1) with integer Bresenham stepping.
- Works for any octant and direction, not only vertical top-down.
- Emits row-granular writes (row address plus WIDTH-bit pixel mask) to the row-organised frame memory, using a valid/ready handshake.
- Merges consecutive pixels on the same row into one write, and rejects out-of-range coordinates.

Parameters:
WIDTH, 640, pixels per row; bits in mem_mask
HEIGHT, 480, rows in frame memory
COORD_W, 16, width of coordinate inputs
ADDR_W, 9, width of mem_addr (must satisfy 2^ADDR_W >= HEIGHT)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; coordinates sampled in the same cycle
x0  in  COORD_W  start x, unsigned
y0  in  COORD_W  start y, unsigned
x1  in  COORD_W  end x, unsigned
y1  in  COORD_W  end y, unsigned
busy  out  1  high from the cycle after an accepted start until the done/err pulse
done  out  1  one-cycle pulse after the last write completes
err  out  1  one-cycle pulse when the request is rejected
mem_we  out  1  write valid
mem_ready  in  1  memory accepts the write when mem_we && mem_ready at a rising edge
mem_addr  out  ADDR_W  row (y) of the write
mem_mask  out  WIDTH  bit i set means pixel x=i is written as 1 (memory ORs the mask into the row)

Behaviour:
- Reset (async, rst_n=0) values: busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_mask=0, state IDLE, all internal registers 0. Reset mid-draw abandons the line with no further writes; no done pulse.
- States: IDLE, CHECK, SETUP, STEP, FLUSH, FINISH.
- IDLE:
  - start=1 latches coordinates and moves to CHECK; busy=1 next cycle.
  - start while busy is ignored.
- CHECK: if any x >= WIDTH or any y >= HEIGHT, pulse err=1 for one cycle, busy=0, return to IDLE, no write issued. Otherwise go to SETUP.
- SETUP:
  - dx=|x1-x0|, dy=|y1-y0|; sx=+1 if x1>=x0 else -1; sy likewise.
  - Error term e=dx-dy, signed, COORD_W+2 bits.
  - Current point (cx,cy)=(x0,y0); row accumulator acc = one-hot(cx); racc_y=cy.
- STEP, one Bresenham step per cycle unless stalled:
  - If (cx,cy)==(x1,y1), go to FLUSH.
  - Else with e2=2e: if e2 > -dy, then e-=dy and cx+=sx; if e2 < dx, then e+=dx and cy+=sy.
  - New point with cy unchanged: acc |= one-hot(cx).
  - New point with cy changed: acc becomes the pending write (mem_we=1, mem_addr=racc_y, mem_mask=acc), then acc=one-hot(new cx) and racc_y=new cy.
  - Stall: if a row change occurs while the previous write is still pending (mem_we=1 and mem_ready=0), STEP holds all state that cycle.
- Output hold: mem_addr and mem_mask are stable while mem_we=1 and mem_ready=0. mem_we drops in the cycle after acceptance unless a new write loads in that same edge (back-to-back allowed).
- FLUSH:
  - Wait until there is no pending write, then issue acc as the final write.
  - Wait for its acceptance, then go to FINISH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. A start in this cycle is ignored.
- Endpoints are inclusive. x0==x1 and y0==y1 gives exactly one write with a single bit set.
- Write count always equals |y1-y0|+1, in row order from y0 toward y1.
- Latency with mem_ready held at 1: first write is valid no earlier than 3 cycles after start (CHECK, SETUP, first STEP).
- Vertical line: one pixel per cycle. Total cycles from start to done <= max(dx,dy)+6.

Test Plan:
1. Vertical line (260,60)->(260,200), mem_ready=1 -> exactly 141 writes, mem_addr 60..200 ascending, each mem_mask has only bit 260 set; then one done pulse, busy=0.
2. Horizontal line (10,5)->(20,5), and the reversed line (20,5)->(10,5) -> each produces a single write, addr 5, mask bits 10..20 set and all others 0.
3. Diagonal (0,0)->(3,3), then (3,0)->(0,3) -> 4 writes each. First line: addr 0..3 with bits 0,1,2,3 respectively. Second line: addr 0..3 with bits 3,2,1,0.
4. Backpressure on (5,0)->(5,3): hold mem_ready=0 for 5 cycles at the first write -> mem_we, mem_addr=0, mask bit 5 held unchanged for 5 cycles; 4 writes total; done only after the last acceptance.
5. Rejection: (640,0)->(0,0), and separately y1=480 -> err pulses for one cycle, mem_we never asserted, no done. Start during busy -> ignored and the current line completes unchanged.
6. Reset mid-draw: assert rst_n=0 on the third write of test 1 -> all outputs 0 immediately. After release, a new start on (1,1)->(1,1) gives one write, addr 1, bit 1, then done.
